// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parity modes.
// Also provides the parity-bit helper used when a byte is loaded.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic parity_bit(
        input logic [7:0] data,
        input int         mode
    );
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte stream handshake into the UART transmitter.
// Signals: tvalid/tdata from producer, tready back from sink.
interface uart_tx_if;

    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO, power-of-two depth.
// Ports: clk, rst, push/din, pop/dout, level, full, empty.
module uart_tx_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic [$clog2(depth):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] lvl_full = (aw + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == lvl_full);
    assign empty = (level == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en) level <= level + 1'b1;
            else if (rd_en && !wr_en) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered byte stream to serial frames (8 data bits).
// Ports: clk, rst, s_axis (slave), tx pin, busy, level (FIFO occupancy).
module uart_tx
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 434,
    parameter int fifo_depth     = 4,
    parameter int parity_mode    = PARITY_NONE,
    parameter int stop_bits      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_if.slave                    s_axis,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(fifo_depth):0] level
);

    localparam int cw = $clog2(cycles_per_bit);
    localparam int lw = $clog2(fifo_depth) + 1;
    localparam logic [cw-1:0] cyc_last  = cw'(cycles_per_bit - 1);
    localparam logic [lw-1:0] lvl_full  = lw'(fifo_depth);
    localparam logic [2:0]    stop_last = 3'(stop_bits - 1);

    if (cycles_per_bit < 2) begin : g_bad_cpb
        $error("uart_tx: cycles_per_bit must be >= 2");
    end
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: fifo_depth must be a power of 2 >= 2");
    end
    if (parity_mode < 0 || parity_mode > 2) begin : g_bad_par
        $error("uart_tx: parity_mode must be 0, 1 or 2");
    end
    if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
        $error("uart_tx: stop_bits must be 1 or 2");
    end

    tx_state_t     state;
    tx_state_t     state_n;
    logic [cw-1:0] cyc_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic [7:0]    fifo_dout;
    logic [lw-1:0] level_n;
    logic          fifo_full;
    logic          fifo_empty;
    logic          par_q;
    logic          tx_q;
    logic          tx_n;
    logic          tready_q;
    logic          push;
    logic          pop;
    logic          bit_end;

    assign push          = s_axis.tvalid && tready_q && !fifo_full;
    assign s_axis.tready = tready_q;
    assign bit_end       = (cyc_cnt == cyc_last);
    assign busy          = (state != IDLE) || (level != '0);
    assign tx            = tx_q;

    uart_tx_fifo #(
        .width (8),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s_axis.tdata),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7)
                    state_n = (parity_mode != PARITY_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // Chain straight into the next frame when a byte waits.
                if (bit_end && bit_idx == stop_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is registered, so it is derived from the next state/shift value.
    always_comb begin
        shreg_n = shreg;
        if (pop)
            shreg_n = fifo_dout;
        else if (state == DATA && bit_end)
            shreg_n = shreg >> 1;
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_q;
            default: tx_n = 1'b1;
        endcase
    end

    // Occupancy after this edge; keeps tready exact despite registering.
    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + 1'b1;
        else if (pop && !push)
            level_n = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            tready_q <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
            tready_q <= (level_n != lvl_full);
            if (pop)
                par_q <= parity_bit(fifo_dout, parity_mode);
            if (state == IDLE || bit_end)
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 1'b1;
            if (pop || state_n != state)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven through the stream port.
// A frame-level reference model checks the tx waveform cycle by cycle.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB [4] = '{16, 16, 16, 2};
    localparam int PAR [4] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
    localparam int SB  [4] = '{1, 2, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       tv;
    logic [3:0][7:0]  td;
    wire  [3:0]       rdy;
    wire  [3:0]       txv;
    wire  [3:0]       bsy;
    wire  [3:0][2:0]  lv;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  pbuf  [8];
    int          hs_a  [8];
    int          t0_a  [8];
    int          gp    [8];
    logic [15:0] smp_a [8];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_if bus ();
        assign bus.tvalid = tv[g];
        assign bus.tdata  = td[g];
        assign rdy[g]     = bus.tready;
        uart_tx #(
            .cycles_per_bit (CPB[g]),
            .fifo_depth     (4),
            .parity_mode    (PAR[g]),
            .stop_bits      (SB[g])
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .s_axis (bus.slave),
            .tx     (txv[g]),
            .busy   (bsy[g]),
            .level  (lv[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbits(input int d);
        return 10 + ((PAR[d] != PARITY_NONE) ? 1 : 0) + SB[d] - 1;
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic logic frame_bit(input int d, input logic [7:0] b, input int k);
        int ones;
        ones = $countones(b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && PAR[d] == PARITY_EVEN) return (ones % 2 == 1);
        if (k == 9 && PAR[d] == PARITY_ODD) return (ones % 2 == 0);
        return 1'b1;
    endfunction

    task automatic push(input int d, input logic [7:0] b, output int hs);
        int   w;
        logic r;
        td[d] = b;
        tv[d] = 1'b1;
        w = 0;
        r = 1'b0;
        while (w < 5000) begin
            r = rdy[d];
            @(posedge clk);
            @(negedge clk);
            if (r === 1'b1) break;
            w++;
        end
        hs = cyc;
        chk($sformatf("push d%0d handshake", d), 32'(r), 32'd1);
    endtask

    task automatic rx_frame(input int d, input logic [7:0] eb, input string tag,
                            output int gap, output int t0, output logic [15:0] smp);
        int   len;
        int   bad;
        int   k;
        logic [7:0] rb;
        gap = 0;
        t0  = 0;
        smp = '0;
        while (gap <= 3000) begin
            @(negedge clk);
            if (txv[d] === 1'b0) break;
            gap++;
        end
        t0 = cyc;
        chk({tag, " start seen"}, 32'(gap <= 3000), 32'd1);
        if (gap > 3000) return;
        len = nbits(d) * CPB[d];
        bad = 0;
        rb  = '0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            k = c / CPB[d];
            if (txv[d] !== frame_bit(d, eb, k)) bad++;
            if (c % CPB[d] == CPB[d] / 2) begin
                smp[k] = txv[d];
                if (k >= 1 && k <= 8) rb[k-1] = txv[d];
            end
        end
        chk({tag, " frame shape"}, 32'(bad), 32'd0);
        chk({tag, " byte"}, 32'(rb), 32'(eb));
    endtask

    task automatic run_stream(input int d, input int n);
        fork
            begin
                for (int i = 0; i < n; i++) push(d, pbuf[i], hs_a[i]);
                tv[d] = 1'b0;
            end
            begin
                for (int j = 0; j < n; j++)
                    rx_frame(d, pbuf[j], $sformatf("d%0d f%0d", d, j), gp[j], t0_a[j], smp_a[j]);
            end
        join
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int dummy;
        rst = 1'b1;
        tv  = '0;
        td  = '0;
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(txv), 32'hF);
        chk("reset tready", 32'(rdy), 32'h0);
        chk("reset busy", 32'(bsy), 32'h0);
        chk("reset level", 32'(lv), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("tready after reset", 32'(rdy), 32'hF);

        // Single 0x55 frame and handshake-to-start latency.
        pbuf[0] = 8'h55;
        run_stream(0, 1);
        chk("t1 latency", 32'(t0_a[0] - hs_a[0]), 32'd1);
        @(negedge clk);
        chk("t1 busy after", 32'(bsy[0]), 32'd0);
        chk("t1 level after", 32'(lv[0]), 32'd0);

        // Four back-to-back bytes, no idle gap.
        pbuf[0] = 8'h00; pbuf[1] = 8'hFF; pbuf[2] = 8'hA5; pbuf[3] = 8'h3C;
        run_stream(0, 4);
        chk("t2 handshakes", 32'(hs_a[3] - hs_a[0]), 32'd3);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t2 gap %0d", i), 32'(gp[i]), 32'd0);
        chk("t2 span", 32'(t0_a[3] - t0_a[0]), 32'd480);
        @(negedge clk);
        chk("t2 busy after", 32'(bsy[0]), 32'd0);

        // Six bytes against depth 4 with tvalid held high.
        for (int i = 0; i < 6; i++) pbuf[i] = 8'($urandom);
        fork
            run_stream(0, 6);
            begin
                repeat (20) @(negedge clk);
                chk("t3 level full", 32'(lv[0]), 32'd4);
                chk("t3 tready full", 32'(rdy[0]), 32'd0);
                chk("t3 busy", 32'(bsy[0]), 32'd1);
            end
        join
        chk("t3 first five", 32'(hs_a[4] - hs_a[0]), 32'd4);
        chk("t3 sixth after pop", 32'(hs_a[5] - t0_a[1]), 32'd1);
        for (int i = 1; i < 6; i++)
            chk($sformatf("t3 gap %0d", i), 32'(gp[i]), 32'd0);
        @(negedge clk);
        chk("t3 idle", 32'(bsy[0]), 32'd0);

        // Even parity with two stop bits, then odd parity.
        pbuf[0] = 8'h07;
        pbuf[1] = 8'($urandom);
        run_stream(1, 2);
        chk("t4 even parity bit", 32'(smp_a[0][9]), 32'd1);
        chk("t4 two-stop length", 32'(t0_a[1] - t0_a[0]), 32'd192);
        chk("t4 even gap", 32'(gp[1]), 32'd0);
        pbuf[0] = 8'h07;
        run_stream(2, 1);
        chk("t4 odd parity bit", 32'(smp_a[0][9]), 32'd0);
        chk("t4 odd latency", 32'(t0_a[0] - hs_a[0]), 32'd1);
        @(negedge clk);
        chk("t4 idle", 32'(bsy), 32'd0);

        // Reset in the middle of a data bit with bytes still queued.
        push(0, 8'hC3, dummy);
        push(0, 8'h5A, dummy);
        push(0, 8'hE7, dummy);
        tv[0] = 1'b0;
        repeat (53) @(negedge clk);
        chk("t5 busy before rst", 32'(bsy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 tx in rst", 32'(txv[0]), 32'd1);
        chk("t5 level in rst", 32'(lv[0]), 32'd0);
        chk("t5 tready in rst", 32'(rdy[0]), 32'd0);
        chk("t5 busy in rst", 32'(bsy[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5 tready after rst", 32'(rdy[0]), 32'd1);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (txv[0] !== 1'b1) lows++;
        end
        chk("t5 no resumed frame", 32'(lows), 32'd0);
        chk("t5 idle", 32'(bsy[0]), 32'd0);
        pbuf[0] = 8'h81;
        run_stream(0, 1);
        chk("t5 latency", 32'(t0_a[0] - hs_a[0]), 32'd1);

        // Two cycles per bit, eight random bytes streamed.
        for (int i = 0; i < 8; i++) pbuf[i] = 8'($urandom);
        run_stream(3, 8);
        for (int i = 1; i < 8; i++)
            chk($sformatf("t6 period %0d", i), 32'(t0_a[i] - t0_a[i-1]), 32'd20);
        @(negedge clk);
        chk("t6 idle", 32'(bsy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
